// File: rtl/apb_adc_sequencer.sv
// APB3 slave that paces conversions on an external SAR ADC, buffers results
// in a small FIFO and raises a registered interrupt toward the NVIC.
module apb_adc_sequencer #(
  parameter int ADC_WIDTH  = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [13:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 adc_start,
  input  logic                 adc_eoc,
  output logic                 adc_oe,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic                 irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CONV, READ} state_t;

  state_t         state_q, state_d;
  logic           en_q, en_d, ie_q, ie_d;
  logic           start_q, start_d;
  logic           ovf_q, ovf_d, toerr_q, toerr_d, irq_q, irq_d;
  logic [15:0]    div_q, div_d, per_q, per_d;
  logic [TW-1:0]  to_q, to_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q;
  logic [ADC_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic       access, wr_en, rd_en;
  logic [1:0] sel;
  logic       wr_ctrl, wr_div, wr_stat, rd_data;
  logic       empty, full, pop, push, ovf_set, toerr_set;
  logic       start_wr, launch;
  logic       unused_ok;

  assign access  = PSEL & PENABLE;
  assign wr_en   = access & PWRITE;
  assign rd_en   = access & ~PWRITE;
  assign sel     = PADDR[3:2];
  assign wr_ctrl = wr_en & (sel == 2'd0);
  assign wr_div  = wr_en & (sel == 2'd1);
  assign wr_stat = wr_en & (sel == 2'd2);
  assign rd_data = rd_en & (sel == 2'd3);

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = rd_data & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = (state_q == READ) & (~full | pop);
  assign ovf_set = (state_q == READ) & full & ~pop;

  // start_q marks the adc_start cycle; no new launch may be taken while it is high.
  assign start_wr = wr_ctrl & PWDATA[2];
  assign launch   = (state_q == IDLE) & ~start_q &
                    ((en_q & (per_q == '0)) | start_wr);

  assign unused_ok = ^{PADDR[13:4], PADDR[1:0], PWDATA[31:18]};

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    toerr_set = 1'b0;
    case (state_q)
      IDLE: if (start_q) state_d = CONV;
      CONV: begin
        if (adc_eoc) begin
          state_d = READ;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          toerr_set = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (launch) to_d = '0;
  end

  always_comb begin
    en_d    = wr_ctrl ? PWDATA[0] : en_q;
    ie_d    = wr_ctrl ? PWDATA[1] : ie_q;
    div_d   = wr_div  ? PWDATA[15:0] : div_q;
    start_d = launch;
    // Loading DIV-1 makes successive launch decisions exactly DIV cycles apart.
    if (launch)
      per_d = (div_q == '0) ? '0 : div_q - 16'd1;
    else
      per_d = (per_q != '0) ? per_q - 16'd1 : per_q;
    ovf_d   = ovf_set   | (ovf_q   & ~(wr_stat & PWDATA[16]));
    toerr_d = toerr_set | (toerr_q & ~(wr_stat & PWDATA[17]));
    irq_d   = ie_q & (~empty | ovf_q | toerr_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      toerr_q <= 1'b0;
      irq_q   <= 1'b0;
      div_q   <= '0;
      per_q   <= '0;
      to_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
      toerr_q <= toerr_d;
      irq_q   <= irq_d;
      div_q   <= div_d;
      per_q   <= per_d;
      to_q    <= to_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wptr_q] <= adc_data;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (sel)
        2'd0: PRDATA[1:0]  = {ie_q, en_q};
        2'd1: PRDATA[15:0] = div_q;
        2'd2: begin
          PRDATA[4:0] = 5'(cnt_q);
          PRDATA[8]   = empty;
          PRDATA[9]   = full;
          PRDATA[10]  = (state_q != IDLE);
          PRDATA[16]  = ovf_q;
          PRDATA[17]  = toerr_q;
        end
        default: if (!empty) PRDATA[ADC_WIDTH-1:0] = mem_q[rptr_q];
      endcase
    end
  end

  assign PSLVERR   = rd_data & empty;
  assign PREADY    = 1'b1;
  assign adc_start = start_q;
  assign adc_oe    = (state_q == READ);
  assign irq       = irq_q;

endmodule

// File: tb/tb_apb_adc_sequencer.sv
// Bench for apb_adc_sequencer: register vector table, behavioural ADC with a
// sample scoreboard, and directed sequences for pacing, timeout and resets.
module tb_apb_adc_sequencer;

  localparam int DEPTH = 8;
  localparam logic [13:0] A_CTRL = 14'h0, A_DIV = 14'h4, A_STAT = 14'h8, A_DATA = 14'hC;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [13:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, adc_start, adc_oe, irq;
  logic        adc_eoc = 1'b0;
  logic [11:0] adc_data = '0;

  apb_adc_sequencer #(.ADC_WIDTH(12), .FIFO_DEPTH(DEPTH), .TIMEOUT(255)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .adc_start(adc_start), .adc_eoc(adc_eoc), .adc_oe(adc_oe), .adc_data(adc_data), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int          n_cmp = 0, n_bad = 0;
  logic [11:0] sb[$];
  bit          exp_ovf = 0, exp_toerr = 0;
  int          cyc = 0, cd = 0, eoc_dly = 3, start_cnt = 0, oe_cnt = 0, prev_start = 0;
  bit          eoc_en = 1, chk_gap = 0, have_prev = 0;
  logic [11:0] data_seed = 12'h000;

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ADC model: EOC eoc_dly cycles after a start, sample captured into the
  // scoreboard when adc_oe is seen, dropped (overflow) if the model FIFO is full.
  always @(negedge PCLK) begin
    cyc++;
    if (PRESET) begin
      cd = 0;
      adc_eoc = 1'b0;
    end else begin
      if (adc_oe) begin
        oe_cnt++;
        adc_eoc = 1'b0;
        if (sb.size() < DEPTH) sb.push_back(adc_data);
        else exp_ovf = 1;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0 && eoc_en) adc_eoc = 1'b1;
      end
      if (adc_start) begin
        start_cnt++;
        if (chk_gap && have_prev) chk("start_gap", cyc - prev_start, 20);
        prev_start = cyc;
        have_prev  = 1;
        cd         = eoc_dly;
        adc_data   = data_seed;
        data_seed  = data_seed + 12'h111;
      end
    end
  end

  function automatic logic [31:0] exp_stat(input bit busy);
    logic [31:0] s = '0;
    s[4:0] = 5'(sb.size());
    s[8]   = (sb.size() == 0);
    s[9]   = (sb.size() == DEPTH);
    s[10]  = busy;
    s[16]  = exp_ovf;
    s[17]  = exp_toerr;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic apb(input bit wr, input logic [13:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #3 rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    logic [31:0] r; logic e;
    apb(1'b1, a, d, r, e);
    chk("wr_slverr", {31'b0, e}, 32'h0);
  endtask

  task automatic rd_chk(input string nm, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] r; logic e;
    apb(1'b0, a, 32'h0, r, e);
    chk(nm, r, exp);
  endtask

  // Pops the scoreboard at the access-phase sample so a same-cycle push sees the freed slot.
  task automatic rd_data(input string nm);
    logic [11:0] e;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_DATA;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(nm, PRDATA, {20'b0, e});
      chk({nm, "_err"}, {31'b0, PSLVERR}, 32'h0);
    end else begin
      chk(nm, PRDATA, 32'h0);
      chk({nm, "_err"}, {31'b0, PSLVERR}, 32'h1);
    end
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_oe(input int target, input int budget);
    int k = 0;
    while (oe_cnt < target && k < budget) begin tick(1); k++; end
    if (oe_cnt < target) chk("wait_oe_timeout", oe_cnt, target);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (adc_start !== 1'b1 && k < budget) begin tick(1); k++; end
    if (adc_start !== 1'b1) chk("wait_start_timeout", {31'b0, adc_start}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bs, bo, k;
    logic [31:0] r; logic e;

    tbl[0]  = '{0, A_STAT, 32'h0,        32'h100,  0};
    tbl[1]  = '{0, A_CTRL, 32'h0,        32'h0,    0};
    tbl[2]  = '{0, A_DIV,  32'h0,        32'h0,    0};
    tbl[3]  = '{1, A_DIV,  32'hFFFF1234, 32'h0,    0};
    tbl[4]  = '{0, A_DIV,  32'h0,        32'h1234, 0};
    tbl[5]  = '{1, A_CTRL, 32'h2,        32'h0,    0};
    tbl[6]  = '{0, A_CTRL, 32'h0,        32'h2,    0};
    tbl[7]  = '{0, A_DATA, 32'h0,        32'h0,    1};
    tbl[8]  = '{1, A_CTRL, 32'h0,        32'h0,    0};
    tbl[9]  = '{0, A_STAT, 32'h0,        32'h100,  0};
    tbl[10] = '{1, A_DIV,  32'h0,        32'h0,    0};

    // reset for two cycles
    @(posedge PCLK); #1;
    tick(1);
    PRESET = 1'b0;
    chk("rst_adc_start", {31'b0, adc_start}, 32'h0);
    chk("rst_adc_oe",    {31'b0, adc_oe},    32'h0);
    chk("rst_irq",       {31'b0, irq},       32'h0);
    chk("rst_pready",    {31'b0, PREADY},    32'h1);
    chk("rst_prdata",    PRDATA,             32'h0);
    chk("rst_pslverr",   {31'b0, PSLVERR},   32'h0);

    for (int i = 0; i < 11; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, r, e);
      if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp);
      chk($sformatf("vec%0d_slverr", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
    end
    chk("idle_prdata", PRDATA, 32'h0);

    // one-shot with IE
    eoc_dly = 5; data_seed = 12'hABC; bs = start_cnt; bo = oe_cnt;
    wr(A_CTRL, 32'h6);
    chk("start_at_T1", {31'b0, adc_start}, 32'h1);
    tick(1);
    chk("start_one_cycle", {31'b0, adc_start}, 32'h0);
    wait_oe(bo + 1, 40);
    tick(2);
    chk("oneshot_starts", start_cnt - bs, 1);
    chk("oneshot_oes",    oe_cnt - bo,    1);
    chk("oneshot_irq",    {31'b0, irq},   32'h1);
    rd_chk("oneshot_status", A_STAT, exp_stat(0));
    rd_data("oneshot_data");
    tick(1);
    chk("irq_after_pop", {31'b0, irq}, 32'h0);
    rd_chk("status_after_pop", A_STAT, 32'h100);

    // continuous pacing, fill and overflow
    eoc_dly = 3; data_seed = 12'h100;
    wr(A_DIV, 32'd20);
    have_prev = 0; chk_gap = 1; bo = oe_cnt;
    wr(A_CTRL, 32'h1);
    wait_oe(bo + 9, 400);
    chk_gap = 0;
    wr(A_CTRL, 32'h0);
    tick(2);
    rd_chk("ovf_status_model", A_STAT, exp_stat(0));
    rd_chk("ovf_status_const", A_STAT, 32'h10208);
    wr(A_STAT, 32'h10000);
    exp_ovf = 0;
    rd_chk("ovf_cleared", A_STAT, 32'h208);
    for (int i = 0; i < DEPTH; i++) rd_data($sformatf("fifo_order%0d", i));
    rd_chk("drained_status", A_STAT, 32'h100);

    // EOC timeout
    eoc_en = 0;
    wr(A_CTRL, 32'h6);
    tick(254);
    rd_chk("to_last_conv", A_STAT, 32'h500);
    exp_toerr = 1;
    rd_chk("to_set", A_STAT, exp_stat(0));
    chk("to_irq", {31'b0, irq}, 32'h1);
    wr(A_STAT, 32'h20000);
    exp_toerr = 0;
    tick(1);
    chk("to_irq_clear", {31'b0, irq}, 32'h0);
    wr(A_CTRL, 32'h0);
    eoc_en = 1;

    // empty read, then pop and push on a full FIFO in the same cycle
    rd_data("empty_read");
    rd_chk("empty_nochange", A_STAT, 32'h100);
    eoc_dly = 3;
    wr(A_DIV, 32'd20);
    wr(A_CTRL, 32'h1);
    k = 0;
    while (sb.size() < DEPTH && k < 400) begin tick(1); k++; end
    if (sb.size() < DEPTH) chk("fill_timeout", sb.size(), DEPTH);
    wait_start(40);
    tick(3);
    rd_data("popfull_data");
    wr(A_CTRL, 32'h0);
    tick(2);
    rd_chk("popfull_model", A_STAT, exp_stat(0));
    rd_chk("popfull_const", A_STAT, 32'h208);
    for (int i = 0; i < DEPTH; i++) rd_data($sformatf("popfull_drain%0d", i));

    // reset during CONV
    eoc_dly = 5; bo = oe_cnt;
    wr(A_CTRL, 32'h4);
    wait_oe(bo + 1, 40);
    tick(2);
    eoc_en = 0;
    wr(A_CTRL, 32'h4);
    tick(1);
    PRESET = 1'b1;
    tick(1);
    PRESET = 1'b0;
    sb.delete(); exp_ovf = 0; exp_toerr = 0;
    chk("midrst_oe",    {31'b0, adc_oe},    32'h0);
    chk("midrst_start", {31'b0, adc_start}, 32'h0);
    rd_chk("midrst_status", A_STAT, 32'h100);
    eoc_en = 1;

    // EN cleared while converting
    eoc_dly = 8;
    wr(A_DIV, 32'd20);
    bs = start_cnt; bo = oe_cnt;
    wr(A_CTRL, 32'h1);
    wait_start(20);
    wr(A_CTRL, 32'h0);
    tick(60);
    chk("enclr_starts", start_cnt - bs, 1);
    chk("enclr_oes",    oe_cnt - bo,    1);
    rd_chk("enclr_status", A_STAT, exp_stat(0));
    rd_data("enclr_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
